// File: rtl/feedback_arbiter_pkg.sv
// Shared types and sizing helpers for the feedback pulse arbiter.
package feedback_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_COOLDOWN = 2'd2
  } arb_state_t;

  localparam int OVERRUN_W = 16;

  // Counter width able to hold every value 0..max_cycles.
  function automatic int cycle_width(input longint unsigned max_cycles);
    return $clog2(max_cycles + 64'd1);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin search: first set bit of pending, starting just after pointer.
module rr_priority_picker #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] pointer,
  output logic          found,
  output logic [IW-1:0] index
);

  logic [IW-1:0] cand;

  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(pointer) + k) % N);
      if (!found && pending[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/feedback_pulse_arbiter.sv
// Round-robin arbiter sharing one actuator line between NUM_REQ pulse sources.
module feedback_pulse_arbiter
  import feedback_arbiter_pkg::*;
#(
  parameter  int              NUM_REQ       = 4,
  parameter  int              outputBitSize = 16,
  parameter  longint unsigned maxCycles     = 64'h8000_0000,
  localparam int              CW            = cycle_width(maxCycles),
  localparam int              IW            = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             enable,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*outputBitSize-1:0] reqValue,
  input  logic [CW-1:0]                    pulseCycles,
  input  logic [CW-1:0]                    cooldownCycles,
  input  logic [outputBitSize-1:0]         valueWhenIdle,
  input  logic                             clearOverrun,
  output logic [outputBitSize-1:0]         out,
  output logic [NUM_REQ-1:0]               grant,
  output logic [IW-1:0]                    activeIndex,
  output logic                             busy,
  output logic [NUM_REQ-1:0]               pending,
  output logic [OVERRUN_W-1:0]             overrunCount
);

  arb_state_t                 state, state_d;
  logic [IW-1:0]              ptr;
  logic [CW-1:0]              cnt;
  logic [CW-1:0]              cap_cool;
  logic                       found;
  logic [IW-1:0]              win;
  logic [NUM_REQ-1:0]         win_mask;
  logic                       grant_now;
  logic                       ovr_hit;
  logic [outputBitSize-1:0]   out_d;
  logic [NUM_REQ-1:0]         grant_d;
  logic                       busy_d;

  rr_priority_picker #(.N(NUM_REQ)) u_picker (
    .pending (pending),
    .pointer (ptr),
    .found   (found),
    .index   (win)
  );

  // A source being granted this edge may re-request in the same cycle;
  // that is a fresh request, so it is excluded from the overrun check.
  always_comb begin
    grant_now = enable && (state == ST_IDLE) && found;
    win_mask  = '0;
    if (grant_now) win_mask[win] = 1'b1;
    ovr_hit   = enable && (|(req & pending & ~win_mask));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:     if (found) state_d = ST_ACTIVE;
      ST_ACTIVE:   if (cnt == '0) state_d = (cap_cool == '0) ? ST_IDLE : ST_COOLDOWN;
      ST_COOLDOWN: if (cnt == '0) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (!enable) state_d = ST_IDLE;
  end

  always_comb begin
    out_d   = valueWhenIdle;
    grant_d = '0;
    if (grant_now) begin
      out_d   = reqValue[int'(win)*outputBitSize +: outputBitSize];
      grant_d = win_mask;
    end else if (state_d == ST_ACTIVE) begin
      out_d   = out;
      grant_d = grant;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Registered outputs, request latching and pulse/cooldown counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out          <= '0;
      grant        <= '0;
      busy         <= 1'b0;
      activeIndex  <= '0;
      ptr          <= IW'(NUM_REQ - 1);
      pending      <= '0;
      overrunCount <= '0;
      cnt          <= '0;
      cap_cool     <= '0;
    end else begin
      out     <= out_d;
      grant   <= grant_d;
      busy    <= busy_d;
      pending <= enable ? ((pending & ~win_mask) | req) : '0;

      if (clearOverrun)
        overrunCount <= '0;
      else if (ovr_hit && (overrunCount != '1))
        overrunCount <= overrunCount + OVERRUN_W'(1);

      if (!enable) begin
        cnt <= '0;
      end else if (grant_now) begin
        activeIndex <= win;
        ptr         <= win;
        cnt         <= (pulseCycles == '0) ? '0 : pulseCycles - CW'(1);
        cap_cool    <= cooldownCycles;
      end else if ((state == ST_ACTIVE) && (cnt == '0)) begin
        cnt <= (cap_cool == '0) ? '0 : cap_cool - CW'(1);
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_feedback_pulse_arbiter.sv
// Directed bench with a grant scoreboard for feedback_pulse_arbiter.
module tb_feedback_pulse_arbiter;

  localparam int NR = 4;
  localparam int W  = 16;
  localparam int CW = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*W-1:0]   reqValue;
  logic [CW-1:0]     pulseCycles;
  logic [CW-1:0]     cooldownCycles;
  logic [W-1:0]      valueWhenIdle;
  logic              clearOverrun = 1'b0;
  logic [W-1:0]      out;
  logic [NR-1:0]     grant;
  logic [1:0]        activeIndex;
  logic              busy;
  logic [NR-1:0]     pending;
  logic [15:0]       overrunCount;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int       idx;
    logic [W-1:0] val;
    int       len;
    int       gap;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          mon_len = 0;
  int          idle_n = 0;
  logic [NR-1:0] prev_g = '0;
  logic [W-1:0] vals [NR] = '{16'h1111, 16'h2222, 16'h1234, 16'h4444};

  feedback_pulse_arbiter #(.NUM_REQ(NR), .outputBitSize(W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .req            (req),
    .reqValue       (reqValue),
    .pulseCycles    (pulseCycles),
    .cooldownCycles (cooldownCycles),
    .valueWhenIdle  (valueWhenIdle),
    .clearOverrun   (clearOverrun),
    .out            (out),
    .grant          (grant),
    .activeIndex    (activeIndex),
    .busy           (busy),
    .pending        (pending),
    .overrunCount   (overrunCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_grant(input int idx, input int len, input int gap);
    exp_t e;
    e.idx = idx;
    e.val = vals[idx];
    e.len = len;
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || pending != '0) && n < 300) begin
      tick();
      n++;
    end
    chk("wait_idle_bound", 32'(n < 300), 32'd1);
  endtask

  // Scoreboard consumer: each new grant pops one expected pulse.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_g  = '0;
      mon_len = 0;
      idle_n  = 0;
    end else begin
      if (grant != '0) begin
        if (prev_g == '0) begin
          tests++;
          assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL unexpected_grant observed=%b expected=none", grant);
          end
          if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk("grant_onehot", 32'(grant), 32'(1) << cur.idx);
            chk("activeIndex", 32'(activeIndex), 32'(cur.idx));
            if (cur.gap >= 0) chk("idle_gap", 32'(idle_n), 32'(cur.gap));
          end
          mon_len = 1;
        end else begin
          mon_len++;
        end
        chk("pulse_out", 32'(out), 32'(cur.val));
      end else begin
        if (prev_g != '0) chk("pulse_len", 32'(mon_len), 32'(cur.len));
        idle_n = (prev_g != '0) ? 1 : idle_n + 1;
      end
      prev_g = grant;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < NR; i++) reqValue[i*W +: W] = vals[i];
    pulseCycles    = 32'd3;
    cooldownCycles = 32'd2;
    valueWhenIdle  = 16'h0000;

    // Reset values
    #2;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_activeIndex", 32'(activeIndex), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_overrun", 32'(overrunCount), 32'h0);
    @(negedge clk); @(negedge clk);
    #1 reset_n = 1'b1;
    enable = 1'b1;
    tick();

    // Single request: P=3, C=2
    expect_grant(2, 3, -1);
    req = 4'b0100;
    tick();
    req = '0;
    chk("t1_pending", 32'(pending), 32'h4);
    chk("t1_idle_busy", 32'(busy), 32'h0);
    tick();
    chk("t1_out_c1", 32'(out), 32'h1234);
    chk("t1_grant", 32'(grant), 32'h4);
    chk("t1_busy_act", 32'(busy), 32'h1);
    chk("t1_pending_clr", 32'(pending), 32'h0);
    tick(); tick();
    chk("t1_out_c3", 32'(out), 32'h1234);
    tick();
    chk("t1_cool1_out", 32'(out), 32'h0);
    chk("t1_cool1_busy", 32'(busy), 32'h1);
    chk("t1_cool1_grant", 32'(grant), 32'h0);
    tick();
    chk("t1_cool2_busy", 32'(busy), 32'h1);
    tick();
    chk("t1_done_busy", 32'(busy), 32'h0);
    tick();

    // Simultaneous requests from a fresh reset
    @(negedge clk); #1 reset_n = 1'b0;
    @(negedge clk); #1 reset_n = 1'b1;
    tick();
    expect_grant(0, 3, -1);
    expect_grant(1, 3, 3);
    expect_grant(2, 3, 3);
    expect_grant(3, 3, 3);
    req = 4'b1111;
    tick();
    req = '0;
    wait_idle();
    tick();
    chk("t2_overrun", 32'(overrunCount), 32'h0);
    chk("t2_lastIndex", 32'(activeIndex), 32'd3);

    // Overrun while source 0 is active, then clear beating an increment
    pulseCycles    = 32'd6;
    cooldownCycles = 32'd1;
    expect_grant(0, 6, -1);
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    chk("t3_grant0", 32'(grant), 32'h1);
    expect_grant(1, 6, 2);
    req = 4'b0010;
    tick(); tick(); tick();
    req = '0;
    chk("t3_overrun2", 32'(overrunCount), 32'd2);
    chk("t3_pending1", 32'(pending), 32'h2);
    req = 4'b0010;
    clearOverrun = 1'b1;
    tick();
    req = '0;
    clearOverrun = 1'b0;
    chk("t3_clear_prio", 32'(overrunCount), 32'd0);
    wait_idle();
    tick();

    // Zero lengths: one-cycle pulses, one idle cycle between
    pulseCycles    = 32'd0;
    cooldownCycles = 32'd0;
    expect_grant(2, 1, -1);
    expect_grant(0, 1, 1);
    req = 4'b0101;
    tick();
    req = '0;
    wait_idle();
    tick();
    chk("t4_overrun", 32'(overrunCount), 32'd0);

    // Disable on the 2nd cycle of a 5-cycle pulse
    pulseCycles    = 32'd5;
    cooldownCycles = 32'd1;
    valueWhenIdle  = 16'h5A5A;
    expect_grant(3, 2, -1);
    req = 4'b1000;
    tick();
    req = '0;
    tick();
    chk("t5_out_act", 32'(out), 32'h4444);
    tick();
    chk("t5_grant_c2", 32'(grant), 32'h8);
    enable = 1'b0;
    tick();
    chk("t5_dis_out", 32'(out), 32'h5A5A);
    chk("t5_dis_grant", 32'(grant), 32'h0);
    chk("t5_dis_busy", 32'(busy), 32'h0);
    chk("t5_dis_pending", 32'(pending), 32'h0);
    req = 4'b1111;
    tick();
    req = '0;
    chk("t5_dis_ignore", 32'(pending), 32'h0);
    tick();
    enable = 1'b1;
    tick(); tick();
    chk("t5_reen_busy", 32'(busy), 32'h0);
    chk("t5_reen_grant", 32'(grant), 32'h0);

    // Async reset in the middle of cooldown
    pulseCycles    = 32'd2;
    cooldownCycles = 32'd4;
    expect_grant(1, 2, -1);
    req = 4'b0010;
    tick();
    req = '0;
    tick(); tick(); tick(); tick();
    chk("t6_cool_busy", 32'(busy), 32'h1);
    chk("t6_cool_grant", 32'(grant), 32'h0);
    chk("t6_cool_out", 32'(out), 32'h5A5A);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_out", 32'(out), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_activeIndex", 32'(activeIndex), 32'h0);
    chk("t6_rst_pending", 32'(pending), 32'h0);
    @(negedge clk); #1 reset_n = 1'b1;
    tick();
    expect_grant(0, 2, -1);
    expect_grant(2, 2, 5);
    req = 4'b0101;
    tick();
    req = '0;
    wait_idle();
    tick(); tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
